// File: rtl/dds_pkg.sv
// Shared FSM state type and default parameter values for the DDS address generator.
package dds_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR   = 2'd1,
    ST_LATCH  = 2'd2,
    ST_STROBE = 2'd3
  } dds_state_e;

  localparam int unsigned DEF_ACC_W      = 32'd24;
  localparam int unsigned DEF_SAMPLE_DIV = 32'd1000;
  localparam int unsigned DEF_FTW_MIN    = 32'd1;

  function automatic int unsigned def_ftw(input int unsigned acc_w);
    return 32'd1 << (acc_w - 32'd8);
  endfunction

  // Narrow accumulators would give a fractional step; fall back to 1.
  function automatic int unsigned def_ftw_step(input int unsigned acc_w);
    if (acc_w < 32'd10) begin
      return 32'd1;
    end else begin
      return 32'd1 << (acc_w - 32'd10);
    end
  endfunction

  function automatic int unsigned def_ftw_max(input int unsigned acc_w);
    return 32'd1 << (acc_w - 32'd1);
  endfunction

endpackage

// File: rtl/dds_addr_gen_btn_edge.sv
// Two-flop synchroniser plus rising-edge pulse for a debounced button level.
module btn_edge
  import dds_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic rise_o
);

  logic [1:0] sync_q;
  logic       hist_q;

  // Flops reset high so a button held through reset release never reads as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      hist_q <= sync_q[1];
    end
  end

  assign rise_o = sync_q[1] & ~hist_q;

endmodule

// File: rtl/dds_addr_gen.sv
// Phase-accumulator DDS address generator: sample divider, four-step sample
// sequencer driving a parallel DAC, and button-controlled frequency tuning word.
module dds_addr_gen
  import dds_pkg::*;
#(
  parameter int unsigned ACC_W       = DEF_ACC_W,
  parameter int unsigned SAMPLE_DIV  = DEF_SAMPLE_DIV,
  parameter int unsigned DEFAULT_FTW = def_ftw(ACC_W),
  parameter int unsigned FTW_STEP    = def_ftw_step(ACC_W),
  parameter int unsigned FTW_MIN     = DEF_FTW_MIN,
  parameter int unsigned FTW_MAX     = def_ftw_max(ACC_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             btn_up,
  input  logic             btn_down,
  output logic [7:0]       address,
  input  logic [7:0]       spo,
  output logic [7:0]       dac_data,
  output logic             dac_wr_n,
  output logic [ACC_W-1:0] ftw
);

  localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);
  localparam int unsigned XW    = ACC_W + 32'd1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 32'd1);
  localparam logic [XW-1:0]    STEP_X   = XW'(FTW_STEP);
  localparam logic [XW-1:0]    MIN_X    = XW'(FTW_MIN);
  localparam logic [XW-1:0]    MAX_X    = XW'(FTW_MAX);
  localparam logic [ACC_W-1:0] RST_FTW  = ACC_W'(DEFAULT_FTW);

  dds_state_e       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       address_q, address_d;
  logic [7:0]       dac_data_q, dac_data_d;
  logic             dac_wr_n_q, dac_wr_n_d;
  logic [ACC_W-1:0] ftw_q, ftw_d;

  logic             tick_s;
  logic             acc_ld_s;
  logic             data_ld_s;
  logic             up_rise_s;
  logic             dn_rise_s;
  logic [ACC_W-1:0] acc_sum_s;
  logic [XW-1:0]    up_sum_s;
  logic [XW-1:0]    dn_diff_s;

  btn_edge u_up (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_up),
    .rise_o (up_rise_s)
  );

  btn_edge u_down (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_down),
    .rise_o (dn_rise_s)
  );

  // Divider parks at zero while disabled so the first tick lands SAMPLE_DIV cycles after enable.
  always_comb begin
    tick_s = en && (div_q == DIV_LAST);
    div_d  = div_q;
    if (!en || tick_s) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: only IDLE waits for a tick; a started sample always runs to STROBE.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:   state_d = tick_s ? ST_ADDR : ST_IDLE;
      ST_ADDR:   state_d = ST_LATCH;
      ST_LATCH:  state_d = ST_STROBE;
      ST_STROBE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Sequencer load enables.
  always_comb begin
    acc_ld_s  = 1'b0;
    data_ld_s = 1'b0;
    case (state_q)
      ST_IDLE:   acc_ld_s  = tick_s;
      ST_ADDR:   data_ld_s = 1'b1;
      ST_LATCH:  data_ld_s = 1'b0;
      ST_STROBE: data_ld_s = 1'b0;
      default: begin
        acc_ld_s  = 1'b0;
        data_ld_s = 1'b0;
      end
    endcase
  end

  // Datapath next values; tuning-word math is one bit wider so clamps see true overflow.
  always_comb begin
    acc_sum_s  = acc_q + ftw_q;
    up_sum_s   = {1'b0, ftw_q} + STEP_X;
    dn_diff_s  = {1'b0, ftw_q} - STEP_X;
    acc_d      = acc_q;
    address_d  = address_q;
    dac_data_d = dac_data_q;
    ftw_d      = ftw_q;
    dac_wr_n_d = (state_d != ST_STROBE);
    if (acc_ld_s) begin
      acc_d     = acc_sum_s;
      address_d = acc_sum_s[ACC_W-1 -: 8];
    end else begin
      acc_d     = acc_q;
      address_d = address_q;
    end
    if (data_ld_s) begin
      dac_data_d = spo;
    end else begin
      dac_data_d = dac_data_q;
    end
    if (up_rise_s && !dn_rise_s) begin
      ftw_d = (up_sum_s > MAX_X) ? MAX_X[ACC_W-1:0] : up_sum_s[ACC_W-1:0];
    end else if (dn_rise_s && !up_rise_s) begin
      ftw_d = (dn_diff_s[ACC_W] || (dn_diff_s < MIN_X)) ? MIN_X[ACC_W-1:0] : dn_diff_s[ACC_W-1:0];
    end else begin
      ftw_d = ftw_q;
    end
  end

  // Datapath registers; reset also cancels any strobe of a sample in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      acc_q      <= '0;
      address_q  <= 8'h00;
      dac_data_q <= 8'h00;
      dac_wr_n_q <= 1'b1;
      ftw_q      <= RST_FTW;
    end else begin
      div_q      <= div_d;
      acc_q      <= acc_d;
      address_q  <= address_d;
      dac_data_q <= dac_data_d;
      dac_wr_n_q <= dac_wr_n_d;
      ftw_q      <= ftw_d;
    end
  end

  assign address  = address_q;
  assign dac_data = dac_data_q;
  assign dac_wr_n = dac_wr_n_q;
  assign ftw      = ftw_q;

endmodule

// File: tb/tb_dds_addr_gen.sv
// Randomised self-checking bench for dds_addr_gen against a transaction-level phase model.
module tb_dds_addr_gen;

  localparam int ACC_W = 16;
  localparam int MOD   = 65536;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        btn_up;
  logic        btn_down;
  logic [7:0]  address;
  logic [7:0]  spo;
  logic [7:0]  dac_data;
  logic        dac_wr_n;
  logic [15:0] ftw;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int strobes = 0;
  int last_strobe_cyc = -1;
  int m_acc;
  int m_ftw;
  logic period_chk = 1'b0;
  logic prev_wr_n = 1'b1;

  dds_addr_gen #(
    .ACC_W       (ACC_W),
    .SAMPLE_DIV  (4),
    .DEFAULT_FTW (256),
    .FTW_STEP    (64),
    .FTW_MIN     (1),
    .FTW_MAX     (32768)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .address  (address),
    .spo      (spo),
    .dac_data (dac_data),
    .dac_wr_n (dac_wr_n),
    .ftw      (ftw)
  );

  // Stand-in waveform table: an arbitrary but fixed byte mapping.
  function automatic logic [7:0] spo_f(input logic [7:0] a);
    return 8'((a * 8'd37) ^ 8'hA5);
  endfunction

  assign spo = spo_f(address);

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Each DAC write is one sample: the phase advances by the current tuning word.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (dac_wr_n === 1'b0) begin
        strobes++;
        m_acc = (m_acc + m_ftw) % MOD;
        chk("strobe_addr", address, m_acc / 256);
        chk("strobe_data", dac_data, spo_f(8'(m_acc / 256)));
        chk("strobe_width", prev_wr_n, 1);
        if (period_chk && last_strobe_cyc >= 0) chk("strobe_period", cyc - last_strobe_cyc, 4);
        last_strobe_cyc = cyc;
      end
      prev_wr_n = dac_wr_n;
    end
  end

  task automatic model_press(input logic up, input logic dn);
    if (up && !dn) m_ftw = (m_ftw + 64 > 32768) ? 32768 : m_ftw + 64;
    else if (dn && !up) m_ftw = (m_ftw - 64 < 1) ? 1 : m_ftw - 64;
  endtask

  task automatic press(input logic up, input logic dn);
    @(negedge clk);
    btn_up = up;
    btn_down = dn;
    repeat (3) @(negedge clk);
    btn_up = 1'b0;
    btn_down = 1'b0;
    repeat (3) @(negedge clk);
    model_press(up, dn);
  endtask

  // Counts rising edges until address moves; -1 on timeout.
  task automatic wait_addr_change(input int budget, output int edges);
    logic [7:0] a0;
    a0 = address;
    edges = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      if (address !== a0) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic wait_strobes(input int target, input int budget);
    int n;
    n = 0;
    while (strobes < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("strobe_count", strobes, target);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    m_acc = 0;
    m_ftw = 256;
    rst_n = 1'b1;
  endtask

  initial begin
    int e;
    int s0;
    int n;
    rst_n = 1'b0;
    en = 1'b0;
    btn_up = 1'b0;
    btn_down = 1'b0;
    m_acc = 0;
    m_ftw = 256;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_address", address, 0);
    chk("rst_dac_data", dac_data, 0);
    chk("rst_wr_n", dac_wr_n, 1);
    chk("rst_ftw", ftw, 256);

    // 20 samples at the reset tuning word, then drop enable in ADDR.
    period_chk = 1'b1;
    last_strobe_cyc = -1;
    s0 = strobes;
    en = 1'b1;
    wait_addr_change(20, e);
    chk("first_tick_lat", e, 4);
    wait_strobes(s0 + 20, 120);
    wait_addr_change(10, e);
    en = 1'b0;
    chk("addr_before_drop", address, 21);
    wait_strobes(s0 + 21, 10);
    repeat (16) @(negedge clk);
    chk("no_extra_strobe", strobes, s0 + 21);
    chk("addr_held", address, 21);
    period_chk = 1'b0;

    en = 1'b1;
    wait_addr_change(20, e);
    chk("reraise_lat", e, 4);
    en = 1'b0;
    repeat (8) @(negedge clk);

    // Button stepping and clamps.
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0);
    chk("ftw_up3", ftw, 448);
    for (int i = 0; i < 10; i++) press(1'b0, 1'b1);
    chk("ftw_down_clamp", ftw, 1);
    press(1'b1, 1'b1);
    chk("ftw_both", ftw, 1);
    for (int i = 0; i < 14; i++) begin
      n = $urandom_range(0, 2);
      press(n != 1, n != 0);
      chk("ftw_rand", ftw, m_ftw);
    end

    // Random-length sample bursts at random tuning words.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) press($urandom_range(0, 1) == 1, 1'b0);
      chk("ftw_burst", ftw, m_ftw);
      n = $urandom_range(3, 8);
      s0 = strobes;
      en = 1'b1;
      wait_strobes(s0 + n, 4 * n + 20);
      en = 1'b0;
      repeat (10) @(negedge clk);
      chk("burst_stop", strobes, s0 + n);
    end

    for (int i = 0; i < 520; i++) press(1'b1, 1'b0);
    chk("ftw_max", ftw, 32768);
    press(1'b1, 1'b0);
    chk("ftw_up_clamp", ftw, 32768);
    press(1'b1, 1'b1);
    chk("ftw_both_max", ftw, 32768);

    // Half-scale tuning word: address alternates by 0x80 across the wrap.
    s0 = strobes;
    en = 1'b1;
    wait_strobes(s0 + 3, 40);
    en = 1'b0;
    repeat (8) @(negedge clk);

    // Button held high across reset release.
    btn_up = 1'b1;
    do_reset();
    repeat (8) @(negedge clk);
    chk("held_btn_ftw", ftw, 256);
    btn_up = 1'b0;
    repeat (6) @(negedge clk);
    chk("held_btn_release", ftw, 256);

    // Reset asserted while in LATCH.
    en = 1'b1;
    wait_addr_change(20, e);
    chk("post_rst_lat", e, 4);
    chk("post_rst_addr", address, 1);
    @(posedge clk);
    #1;
    chk("latch_data", dac_data, spo_f(8'd1));
    chk("latch_wr_n", dac_wr_n, 1);
    s0 = strobes;
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    chk("abort_address", address, 0);
    chk("abort_data", dac_data, 0);
    chk("abort_wr_n", dac_wr_n, 1);
    chk("abort_ftw", ftw, 256);
    @(negedge clk);
    m_acc = 0;
    m_ftw = 256;
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_strobe", strobes, s0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dds_addr_gen.md
DDS_ADDR_GEN -- requirements
Module: dds_addr_gen

Interface
REQ-001 Parameter ACC_W, default 24: phase accumulator width; legal range 8..32.
REQ-002 Parameter SAMPLE_DIV, default 1000: clk cycles per sample tick; minimum 4.
REQ-003 Parameter DEFAULT_FTW, default 2**(ACC_W-8): frequency tuning word after reset.
REQ-004 Parameter FTW_STEP, default 2**(ACC_W-10): FTW increment/decrement per button press.
REQ-005 Parameters FTW_MIN, default 1, and FTW_MAX, default 2**(ACC_W-1): FTW clamp limits.
REQ-006 clk  input  1  single system clock; all state on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 en  input  1  synchronous run enable; high = generate samples.
REQ-009 btn_up  input  1  raw asynchronous level, already debounced; rising edge raises FTW.
REQ-010 btn_down  input  1  raw asynchronous level, already debounced; rising edge lowers FTW.
REQ-011 address  output  8  registered lookup address to the waveform-select block.
REQ-012 spo  input  8  combinational sample returned for the current address.
REQ-013 dac_data  output  8  registered sample driven to the parallel DAC.
REQ-014 dac_wr_n  output  1  DAC write strobe, active low, one clk wide.
REQ-015 ftw  output  ACC_W  current tuning word, for display.

Function
REQ-016 Divider counts 0..SAMPLE_DIV-1 while en=1 and emits a one-cycle tick on the wrap to 0.
REQ-017 Divider holds at 0 while en=0, so the first tick comes SAMPLE_DIV cycles after en rises.
REQ-018 FSM states: IDLE, ADDR, LATCH, STROBE; IDLE->ADDR on tick, ADDR->LATCH, LATCH->STROBE, STROBE->IDLE, each unconditional after one cycle.
REQ-019 IDLE->ADDR: acc <= (acc + ftw) mod 2**ACC_W and address <= top 8 bits of the new acc, both in the same cycle.
REQ-020 LATCH: dac_data <= spo, sampled one cycle after address changed.
REQ-021 STROBE: dac_wr_n = 0 for exactly this cycle; dac_data stays stable from LATCH until the next LATCH.
REQ-022 Latency: tick at cycle T -> address valid at T+1 -> dac_data at T+2 -> dac_wr_n low during T+3.
REQ-023 Accumulator wrap-around is silent and modular; no overflow flag.
REQ-024 btn_up/btn_down each pass through a 2-flop synchroniser followed by rising-edge detection.
REQ-025 Up edge: ftw <= min(ftw + FTW_STEP, FTW_MAX); down edge: ftw <= max(ftw - FTW_STEP, FTW_MIN); arithmetic is computed ACC_W+1 wide to avoid wrap.
REQ-026 Up and down edges in the same cycle leave ftw unchanged.
REQ-027 An ftw change takes effect at the next IDLE->ADDR transition, never inside a sample in progress.
REQ-028 If en falls mid-sample, the FSM completes the current sample through STROBE, then stays in IDLE.
REQ-029 A button held high through reset release produces no step.

Reset
REQ-030 rst_n low asynchronously sets: acc=0, address=0x00, ftw=DEFAULT_FTW, dac_data=0x00, dac_wr_n=1, FSM=IDLE, divider=0.
REQ-031 Reset also sets the synchroniser and edge-history flops so that REQ-029 holds.
REQ-032 Reset asserted mid-sample aborts the sample immediately: no dac_wr_n pulse is emitted after reset.

Structure
REQ-033 The FSM state enum and the default parameter values live in the shared package dds_pkg.
REQ-034 A single sub-module, btn_edge (2-flop synchroniser plus rising-edge pulse), is instantiated twice; all other logic is flat.

Verification (ACC_W=16, SAMPLE_DIV=4, DEFAULT_FTW=256, FTW_STEP=64, FTW_MIN=1, FTW_MAX=32768 unless noted)
REQ-035 Reset, then en=1 for 20 ticks -> address = 1,2,...,20 on successive ticks; dac_data equals the model spo(address) one cycle later; one dac_wr_n pulse per tick.
REQ-036 Preload acc near the top (ftw=32768, 3 ticks) -> address = 0x80, 0x00, 0x80, with no glitch at the wrap.
REQ-037 btn_up pulsed 3 times -> ftw=448; btn_down pulsed 10 times -> ftw=1 (clamped); btn_up at ftw=32740 -> ftw=32768 (clamped).
REQ-038 btn_up and btn_down rise in the same cycle -> ftw unchanged; button held across rst_n release -> ftw=256.
REQ-039 en dropped in the ADDR state -> LATCH and STROBE still complete with exactly one dac_wr_n pulse, then no further activity; en re-raised -> first tick 4 cycles later.
REQ-040 rst_n asserted in the LATCH state -> outputs take reset values immediately, with no dac_wr_n pulse.
